// File: rtl/trade_order_scheduler.sv
// Order scheduler between the strategy/risk logic and the byte-wide UART TX.
// Latches buy/sell/close requests, arbitrates them with close first, filters
// them against the tracked position and a post-order cooldown, and sends each
// granted order as a 4-byte frame over a valid/ready handshake.
module trade_order_scheduler #(
    parameter int unsigned COOLDOWN_CYCLES = 100_000_000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       req_buy,
    input  logic       req_sell,
    input  logic       req_close,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [1:0] position,
    output logic       cooldown_active,
    output logic [7:0] order_count,
    output logic [7:0] drop_count
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] OP_BUY    = 8'h10;
    localparam logic [7:0] OP_SELL   = 8'h20;
    localparam logic [7:0] OP_CLOSE  = 8'h30;

    localparam logic [1:0] POS_FLAT  = 2'b00;
    localparam logic [1:0] POS_LONG  = 2'b01;
    localparam logic [1:0] POS_SHORT = 2'b10;

    state_t           state_q, state_d;
    logic             pend_buy_q, pend_buy_d;
    logic             pend_sell_q, pend_sell_d;
    logic             pend_close_q, pend_close_d;
    logic [7:0]       op_q, op_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       seq_q, seq_d;
    logic [1:0]       pos_q, pos_d;
    logic [CNT_W-1:0] cd_q, cd_d;
    logic [7:0]       ord_q, ord_d;
    logic [7:0]       drop_q, drop_d;

    logic             grant, drop;
    logic [7:0]       grant_op;
    logic             use_buy, use_sell, use_close;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pend_buy_q   <= 1'b0;
            pend_sell_q  <= 1'b0;
            pend_close_q <= 1'b0;
            op_q         <= '0;
            idx_q        <= '0;
            seq_q        <= '0;
            pos_q        <= POS_FLAT;
            cd_q         <= '0;
            ord_q        <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            pend_buy_q   <= pend_buy_d;
            pend_sell_q  <= pend_sell_d;
            pend_close_q <= pend_close_d;
            op_q         <= op_d;
            idx_q        <= idx_d;
            seq_q        <= seq_d;
            pos_q        <= pos_d;
            cd_q         <= cd_d;
            ord_q        <= ord_d;
            drop_q       <= drop_d;
        end
    end

    // Arbitration, frame sequencing, position/cooldown/counter updates
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        idx_d     = idx_q;
        seq_d     = seq_q;
        pos_d     = pos_q;
        ord_d     = ord_q;
        drop_d    = drop_q;
        cd_d      = (cd_q != '0) ? cd_q - CNT_W'(1) : cd_q;
        grant     = 1'b0;
        drop      = 1'b0;
        grant_op  = '0;
        use_buy   = 1'b0;
        use_sell  = 1'b0;
        use_close = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    if (pend_close_q) begin
                        use_close = 1'b1;
                        if (pos_q == POS_FLAT) begin
                            drop = 1'b1;
                        end else begin
                            grant    = 1'b1;
                            grant_op = OP_CLOSE;
                        end
                    end
                    // A dropped close still lets a buy/sell conflict resolve in
                    // the same cycle; both drops then count once.
                    if (!grant) begin
                        if (pend_buy_q && pend_sell_q) begin
                            use_buy  = 1'b1;
                            use_sell = 1'b1;
                            drop     = 1'b1;
                        end else if (!pend_close_q && cd_q == '0) begin
                            if (pend_buy_q) begin
                                use_buy = 1'b1;
                                if (pos_q == POS_LONG) begin
                                    drop = 1'b1;
                                end else begin
                                    grant    = 1'b1;
                                    grant_op = OP_BUY;
                                end
                            end else if (pend_sell_q) begin
                                use_sell = 1'b1;
                                if (pos_q == POS_SHORT) begin
                                    drop = 1'b1;
                                end else begin
                                    grant    = 1'b1;
                                    grant_op = OP_SELL;
                                end
                            end
                        end
                    end
                end
                if (grant) begin
                    state_d = SEND;
                    op_d    = grant_op;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        seq_d   = seq_q + 8'd1;
                        ord_d   = ord_q + 8'd1;
                        cd_d    = CNT_W'(COOLDOWN_CYCLES);
                        case (op_q)
                            OP_BUY:  pos_d = POS_LONG;
                            OP_SELL: pos_d = POS_SHORT;
                            default: pos_d = POS_FLAT;
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (drop && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end

        pend_buy_d   = enable & ((pend_buy_q   & ~use_buy)   | req_buy);
        pend_sell_d  = enable & ((pend_sell_q  & ~use_sell)  | req_sell);
        pend_close_d = enable & ((pend_close_q & ~use_close) | req_close);
    end

    // Output decode: current frame byte while sending, zero otherwise
    always_comb begin
        tx_valid = (state_q == SEND);
        busy     = (state_q == SEND);
        tx_data  = '0;
        if (state_q == SEND) begin
            case (idx_q)
                2'd0:    tx_data = SYNC_BYTE;
                2'd1:    tx_data = op_q;
                2'd2:    tx_data = seq_q;
                default: tx_data = SYNC_BYTE ^ op_q ^ seq_q;
            endcase
        end
    end

    assign position        = pos_q;
    assign cooldown_active = (cd_q != '0);
    assign order_count     = ord_q;
    assign drop_count      = drop_q;

endmodule

// File: tb/tb_trade_order_scheduler.sv
// Directed bench for trade_order_scheduler with an 8-cycle cooldown.
module tb_trade_order_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       req_buy;
    logic       req_sell;
    logic       req_close;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic [1:0] position;
    logic       cooldown_active;
    logic [7:0] order_count;
    logic [7:0] drop_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    trade_order_scheduler #(
        .COOLDOWN_CYCLES(8),
        .CNT_W          (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .req_buy        (req_buy),
        .req_sell       (req_sell),
        .req_close      (req_close),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .busy           (busy),
        .position       (position),
        .cooldown_active(cooldown_active),
        .order_count    (order_count),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
        chk({tag, "_data"}, 32'(tx_data), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; tx_ready = 1'b1;
        req_buy = 1'b0; req_sell = 1'b0; req_close = 1'b0;
        tick(); tick(); tick();
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_pos", 32'(position), 32'd0);
        chk("rst_orders", 32'(order_count), 32'd0);
        chk("rst_drops", 32'(drop_count), 32'd0);
        chk("rst_cd", 32'(cooldown_active), 32'd0);
        rst_n = 1'b1;
        tick();

        // BUY from flat: valid two cycles after the pulse
        req_buy = 1'b1; tick(); req_buy = 1'b0;
        chk("buy_lat", 32'(tx_valid), 32'd0);
        tick(); chk_byte("buy_b0", 8'hA5);
        chk("buy_busy", 32'(busy), 32'd1);
        tick(); chk_byte("buy_b1", 8'h10);
        tick(); chk_byte("buy_b2", 8'h00);
        tick(); chk_byte("buy_b3", 8'hB5);
        tick();
        chk("buy_end_valid", 32'(tx_valid), 32'd0);
        chk("buy_end_busy", 32'(busy), 32'd0);
        chk("buy_pos", 32'(position), 32'd1);
        chk("buy_orders", 32'(order_count), 32'd1);
        chk("buy_cd", 32'(cooldown_active), 32'd1);

        // SELL issued two cycles into the cooldown waits for it to expire
        tick(); chk("cd_1", 32'(cooldown_active), 32'd1);
        tick(); chk("cd_2", 32'(cooldown_active), 32'd1);
        req_sell = 1'b1; tick(); req_sell = 1'b0;
        chk("cd_3", 32'(cooldown_active), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("cd_hold", 32'(cooldown_active), 32'd1);
            chk("sell_wait", 32'(tx_valid), 32'd0);
        end
        tick();
        chk("cd_expired", 32'(cooldown_active), 32'd0);
        chk("sell_wait_last", 32'(tx_valid), 32'd0);
        tick(); chk_byte("sell_b0", 8'hA5);
        tick(); chk_byte("sell_b1", 8'h20);
        tick(); chk_byte("sell_b2", 8'h01);
        tick(); chk_byte("sell_b3", 8'h84);
        tick();
        chk("sell_end_valid", 32'(tx_valid), 32'd0);
        chk("sell_pos", 32'(position), 32'd2);
        chk("sell_orders", 32'(order_count), 32'd2);

        // CLOSE goes out despite an active cooldown
        chk("close_cd", 32'(cooldown_active), 32'd1);
        req_close = 1'b1; tick(); req_close = 1'b0;
        tick(); chk_byte("close_b0", 8'hA5);
        tick(); chk_byte("close_b1", 8'h30);
        tick(); chk_byte("close_b2", 8'h02);
        tick(); chk_byte("close_b3", 8'h97);
        tick();
        chk("close_end_valid", 32'(tx_valid), 32'd0);
        chk("close_pos", 32'(position), 32'd0);
        chk("close_orders", 32'(order_count), 32'd3);
        chk("close_drops", 32'(drop_count), 32'd0);

        // Close while flat is dropped
        req_close = 1'b1; tick(); req_close = 1'b0;
        tick();
        chk("flat_close_drop", 32'(drop_count), 32'd1);
        chk("flat_close_valid", 32'(tx_valid), 32'd0);

        // Simultaneous buy and sell conflict is dropped
        req_buy = 1'b1; req_sell = 1'b1; tick(); req_buy = 1'b0; req_sell = 1'b0;
        tick();
        chk("conflict_drop", 32'(drop_count), 32'd2);
        tick();
        chk("conflict_valid", 32'(tx_valid), 32'd0);
        chk("conflict_drop_once", 32'(drop_count), 32'd2);

        // Backpressure on byte1
        for (int i = 0; i < 20 && cooldown_active; i++) tick();
        chk("wait_cd1", 32'(cooldown_active), 32'd0);
        req_buy = 1'b1; tick(); req_buy = 1'b0;
        tick(); chk_byte("bp_b0", 8'hA5);
        tick(); chk_byte("bp_b1", 8'h10);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_byte("bp_hold", 8'h10);
        end
        tx_ready = 1'b1;
        tick(); chk_byte("bp_b2", 8'h03);
        tick(); chk_byte("bp_b3", 8'hB6);
        tick();
        chk("bp_end_valid", 32'(tx_valid), 32'd0);
        chk("bp_pos", 32'(position), 32'd1);
        chk("bp_orders", 32'(order_count), 32'd4);

        // Reset mid-frame on byte2
        for (int i = 0; i < 20 && cooldown_active; i++) tick();
        chk("wait_cd2", 32'(cooldown_active), 32'd0);
        req_sell = 1'b1; tick(); req_sell = 1'b0;
        tick(); chk_byte("ab_b0", 8'hA5);
        tick(); chk_byte("ab_b1", 8'h20);
        tick(); chk_byte("ab_b2", 8'h04);
        rst_n = 1'b0;
        tick();
        chk("ab_valid", 32'(tx_valid), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_pos", 32'(position), 32'd0);
        chk("ab_orders", 32'(order_count), 32'd0);
        chk("ab_drops", 32'(drop_count), 32'd0);
        chk("ab_cd", 32'(cooldown_active), 32'd0);
        rst_n = 1'b1;
        tick();

        // Requests ignored while disabled
        enable = 1'b0;
        req_buy = 1'b1; tick(); req_buy = 1'b0;
        tick(); tick();
        chk("dis_valid", 32'(tx_valid), 32'd0);
        enable = 1'b1;

        // Fresh BUY after reset restarts seq at 0
        req_buy = 1'b1; tick(); req_buy = 1'b0;
        tick(); chk_byte("rb_b0", 8'hA5);
        tick(); chk_byte("rb_b1", 8'h10);
        tick(); chk_byte("rb_b2", 8'h00);
        tick(); chk_byte("rb_b3", 8'hB5);
        tick();
        chk("rb_pos", 32'(position), 32'd1);
        chk("rb_orders", 32'(order_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
